fifo_rd_stream: RTL

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_rd_skid.sv | 83 ++++++++
 rtl/fifo_rd_stream.sv | 133 +++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared constants and helpers for the FIFO read-stream block.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int c_rd_latency_min = 1;
    localparam int c_rd_latency_max = 3;

    // Two slots beyond the read latency let the stream run at full rate.
    function automatic int buf_depth(input int rd_latency);
        return rd_latency + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_skid.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_skid
// Description : Small circular capture buffer with push/pop/count and
//               first-word-fall-through head output.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_skid #(
    parameter int DWIDTH = 64,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              i_push,
    input  logic [DWIDTH-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DWIDTH-1:0] o_head,
    output logic [CNT_W-1:0]  o_count
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DWIDTH-1:0]  r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_full;
    logic               w_do_push;
    logic               w_do_pop;
    logic [c_ptr_w-1:0] w_wr_ptr_nxt;
    logic [c_ptr_w-1:0] w_rd_ptr_nxt;

    always_comb begin
        w_full       = (r_count == CNT_W'(DEPTH));
        w_do_pop     = i_pop && (r_count != '0);
        // A full buffer may still accept when the head leaves in the same cycle.
        w_do_push    = i_push && (!w_full || w_do_pop);
        w_wr_ptr_nxt = (r_wr_ptr == c_ptr_w'(DEPTH - 1)) ? '0 : r_wr_ptr + c_ptr_w'(1);
        w_rd_ptr_nxt = (r_rd_ptr == c_ptr_w'(DEPTH - 1)) ? '0 : r_rd_ptr + c_ptr_w'(1);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(i_push && w_full && !i_pop));
`endif

endmodule
`default_nettype wire

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_stream
// Description : Converts a non-showahead FIFO read port into a valid/ready
//               stream. Statistics counters built with FIFO_RD_STREAM_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DWIDTH     = 64,
    parameter int RD_LATENCY = 2,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 fifo_empty_i,
    input  logic [DWIDTH-1:0]    fifo_q_i,
    output logic                 rdreq_o,
    output logic [DWIDTH-1:0]    data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [CNT_WIDTH-1:0] beat_cnt_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o
);

    localparam int c_buf_depth = buf_depth(RD_LATENCY);
    localparam int c_cnt_w     = $clog2(c_buf_depth + 1);
    localparam int c_occ_w     = $clog2(c_buf_depth + RD_LATENCY + 1);

    generate
        if (RD_LATENCY < c_rd_latency_min || RD_LATENCY > c_rd_latency_max) begin : g_bad_latency
            $error("fifo_rd_stream: RD_LATENCY out of range");
        end
    endgenerate

    logic [RD_LATENCY-1:0] r_inflight;
    logic [1:0]            r_init;
    logic [c_cnt_w-1:0]    w_count;
    logic [c_occ_w-1:0]    w_occ;
    logic [DWIDTH-1:0]     w_head;
    logic                  w_rdreq;
    logic                  w_capture;
    logic                  w_valid;
    logic                  w_pop;

    // Occupancy counts words already buffered plus reads still in the FIFO pipe.
    always_comb begin
        w_occ = c_occ_w'(w_count);
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_occ = w_occ + c_occ_w'(r_inflight[i]);
        end
    end

    assign w_rdreq   = r_init[1] && !fifo_empty_i && (w_occ < c_occ_w'(c_buf_depth));
    assign w_capture = r_inflight[RD_LATENCY-1];
    assign w_valid   = (w_count != '0);
    assign w_pop     = w_valid && ready_i;

    // Holds off read requests until the upstream FIFO is out of reset too.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_init <= '0;
        end else begin
            r_init <= {r_init[0], 1'b1};
        end
    end

    generate
        if (RD_LATENCY == 1) begin : g_lat1
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    r_inflight <= '0;
                end else begin
                    r_inflight <= w_rdreq;
                end
            end
        end else begin : g_latn
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    r_inflight <= '0;
                end else begin
                    r_inflight <= {r_inflight[RD_LATENCY-2:0], w_rdreq};
                end
            end
        end
    endgenerate

    fifo_rd_skid #(
        .DWIDTH (DWIDTH),
        .DEPTH  (c_buf_depth),
        .CNT_W  (c_cnt_w)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .i_push      (w_capture),
        .i_push_data (fifo_q_i),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign rdreq_o = w_rdreq;
    assign data_o  = w_head;
    assign valid_o = w_valid;

`ifdef FIFO_RD_STREAM_STATS_EN
    logic [CNT_WIDTH-1:0] r_beat_cnt;
    logic [CNT_WIDTH-1:0] r_stall_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_beat_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_pop) begin
                r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
            end
            if (w_valid && !ready_i) begin
                r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign beat_cnt_o  = r_beat_cnt;
    assign stall_cnt_o = r_stall_cnt;
`else
    assign beat_cnt_o  = '0;
    assign stall_cnt_o = '0;
`endif

endmodule
`default_nettype wire
